// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared constants and types for the fully-connected PE array
//
// Holds the array geometry shared with the PE row, the feeder FSM state type
// and the weight bank type (one DATA_W word per PE).
package fc_pkg;

  localparam int FC_SIZE = 128;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_COMMIT = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4
  } fc_feed_state_t;

  typedef logic [FC_SIZE-1:0][DATA_W-1:0] fc_weight_bank_t;

endpackage

// File: rtl/fc_array_feeder.sv
// rtl/fc_array_feeder.sv - weight/ifmap feeder for the 128-PE fully-connected row
//
// Loads FC_SIZE weights into a shadow bank, commits them to the PE row with a
// one-cycle pe_load_o strobe, streams num_ifmap_i ifmap bytes into PE 0, then
// drains the row with FC_SIZE zero cycles and pulses done_o.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_i, num_ifmap_i     job start (IDLE only) and ifmap byte count
//   w_valid_i/w_data_i/w_ready_o   weight stream, k-th byte goes to PE k
//   x_valid_i/x_data_i/x_ready_o   ifmap stream
//   weight_o, pe_load_o      committed weights and their load strobe
//   ifmap_o, ifmap_valid_o   serial ifmap into PE 0 (zero when not valid)
//   busy_o, done_o           FSM not idle, one-cycle end-of-job pulse
//   stall_cnt_o              only with FC_FEEDER_STALL_CNT_EN: STREAM cycles
//                            without x_valid_i, saturating
//
// Optional feature macro: FC_FEEDER_STALL_CNT_EN
module fc_array_feeder
  import fc_pkg::*;
#(
  parameter int FC_SIZE = fc_pkg::FC_SIZE,
  parameter int DATA_W  = fc_pkg::DATA_W,
  parameter int CNT_W   = fc_pkg::CNT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [CNT_W-1:0]               num_ifmap_i,
  input  logic                           w_valid_i,
  input  logic [DATA_W-1:0]              w_data_i,
  output logic                           w_ready_o,
  input  logic                           x_valid_i,
  input  logic [DATA_W-1:0]              x_data_i,
  output logic                           x_ready_o,
  output logic [FC_SIZE-1:0][DATA_W-1:0] weight_o,
  output logic                           pe_load_o,
  output logic [DATA_W-1:0]              ifmap_o,
  output logic                           ifmap_valid_o,
  output logic                           busy_o,
`ifdef FC_FEEDER_STALL_CNT_EN
  output logic [31:0]                    stall_cnt_o,
`endif
  output logic                           done_o
);

  localparam int IDX_W = $clog2(FC_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FC_SIZE - 1);

  fc_feed_state_t r_state;
  fc_feed_state_t w_next_state;

  logic [CNT_W-1:0]               r_num;
  logic [CNT_W-1:0]               r_x_cnt;
  logic [IDX_W-1:0]               r_w_idx;
  logic [IDX_W-1:0]               r_drain_cnt;
  logic [FC_SIZE-1:0][DATA_W-1:0] r_shadow;
  logic [FC_SIZE-1:0][DATA_W-1:0] r_weight;
  logic                           r_pe_load;
  logic [DATA_W-1:0]              r_ifmap;
  logic                           r_ifmap_valid;
  logic                           r_done;
`ifdef FC_FEEDER_STALL_CNT_EN
  logic [31:0]                    r_stall_cnt;
`endif

  logic w_w_hs;
  logic w_x_hs;
  logic w_last_x;

  assign w_w_hs   = (r_state == ST_LOAD_W) && w_valid_i;
  assign w_x_hs   = (r_state == ST_STREAM) && x_valid_i;
  assign w_last_x = (r_x_cnt == (r_num - CNT_W'(1)));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (start_i) w_next_state = ST_LOAD_W;
      ST_LOAD_W: if (w_w_hs && (r_w_idx == LAST_IDX)) w_next_state = ST_COMMIT;
      ST_COMMIT: w_next_state = (r_num != '0) ? ST_STREAM : ST_DRAIN;
      ST_STREAM: if (w_x_hs && w_last_x) w_next_state = ST_DRAIN;
      // done_o is raised while still in DRAIN so a coincident start_i is ignored
      ST_DRAIN:  if (r_done) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_num         <= '0;
      r_x_cnt       <= '0;
      r_w_idx       <= '0;
      r_drain_cnt   <= '0;
      r_shadow      <= '0;
      r_weight      <= '0;
      r_pe_load     <= 1'b0;
      r_ifmap       <= '0;
      r_ifmap_valid <= 1'b0;
      r_done        <= 1'b0;
`ifdef FC_FEEDER_STALL_CNT_EN
      r_stall_cnt   <= '0;
`endif
    end else begin
      r_state       <= w_next_state;
      r_pe_load     <= (r_state == ST_COMMIT);
      // Non-handshake cycles push a zero bubble so the row never sees stale data.
      r_ifmap       <= w_x_hs ? x_data_i : '0;
      r_ifmap_valid <= w_x_hs;
      r_done        <= (r_state == ST_DRAIN) && !r_done && (r_drain_cnt == LAST_IDX);

      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_num       <= num_ifmap_i;
            r_x_cnt     <= '0;
            r_w_idx     <= '0;
            r_drain_cnt <= '0;
`ifdef FC_FEEDER_STALL_CNT_EN
            r_stall_cnt <= '0;
`endif
          end
        end
        ST_LOAD_W: begin
          if (w_w_hs) begin
            r_shadow[r_w_idx] <= w_data_i;
            r_w_idx           <= r_w_idx + IDX_W'(1);
          end
        end
        ST_COMMIT: begin
          r_weight <= r_shadow;
        end
        ST_STREAM: begin
          if (w_x_hs) begin
            r_x_cnt <= r_x_cnt + CNT_W'(1);
          end
`ifdef FC_FEEDER_STALL_CNT_EN
          if (!x_valid_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
          end
`endif
        end
        ST_DRAIN: begin
          if (!r_done) begin
            r_drain_cnt <= r_drain_cnt + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_ready_o     = (r_state == ST_LOAD_W);
  assign x_ready_o     = (r_state == ST_STREAM);
  assign busy_o        = (r_state != ST_IDLE);
  assign weight_o      = r_weight;
  assign pe_load_o     = r_pe_load;
  assign ifmap_o       = r_ifmap;
  assign ifmap_valid_o = r_ifmap_valid;
  assign done_o        = r_done;
`ifdef FC_FEEDER_STALL_CNT_EN
  assign stall_cnt_o   = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fc_array_feeder.sv
// tb/tb_fc_array_feeder.sv - self-checking bench for fc_array_feeder
module tb_fc_array_feeder;
  import fc_pkg::*;

  localparam int P_IDLE   = 0;
  localparam int P_LOAD   = 1;
  localparam int P_COMMIT = 2;
  localparam int P_STREAM = 3;
  localparam int P_DRAIN  = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start_i = 1'b0;
  logic [CNT_W-1:0]   num_ifmap_i = '0;
  logic               w_valid_i = 1'b0;
  logic [DATA_W-1:0]  w_data_i = '0;
  logic               w_ready_o;
  logic               x_valid_i = 1'b0;
  logic [DATA_W-1:0]  x_data_i = '0;
  logic               x_ready_o;
  fc_weight_bank_t    weight_o;
  logic               pe_load_o;
  logic [DATA_W-1:0]  ifmap_o;
  logic               ifmap_valid_o;
  logic               busy_o;
  logic               done_o;
`ifdef FC_FEEDER_STALL_CNT_EN
  logic [31:0]        stall_cnt_o;
`endif

  always #5 clk = ~clk;

  fc_array_feeder dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .num_ifmap_i   (num_ifmap_i),
    .w_valid_i     (w_valid_i),
    .w_data_i      (w_data_i),
    .w_ready_o     (w_ready_o),
    .x_valid_i     (x_valid_i),
    .x_data_i      (x_data_i),
    .x_ready_o     (x_ready_o),
    .weight_o      (weight_o),
    .pe_load_o     (pe_load_o),
    .ifmap_o       (ifmap_o),
    .ifmap_valid_o (ifmap_valid_o),
    .busy_o        (busy_o),
`ifdef FC_FEEDER_STALL_CNT_EN
    .stall_cnt_o   (stall_cnt_o),
`endif
    .done_o        (done_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: job-level phase plus counts of accepted bytes
  int              m_phase = P_IDLE;
  int              m_num, m_wcnt, m_xcnt, m_dcnt;
  longint          m_stall;
  fc_weight_bank_t m_shadow, m_wout;
  logic            m_load, m_done, m_ifv;
  logic [7:0]      m_if;
  bit              m_live = 0;

  always @(posedge clk) begin : model
    logic [7:0] nx_if;
    logic       nx_ifv, nx_load, nx_done;
    if (rst) begin
      m_phase = P_IDLE; m_num = 0; m_wcnt = 0; m_xcnt = 0; m_dcnt = 0; m_stall = 0;
      m_shadow = '0; m_wout = '0; m_load = 0; m_done = 0; m_ifv = 0; m_if = '0;
      m_live = 1;
    end else begin
      nx_ifv  = (m_phase == P_STREAM) && x_valid_i;
      nx_if   = nx_ifv ? x_data_i : 8'h00;
      nx_load = (m_phase == P_COMMIT);
      nx_done = 0;
      case (m_phase)
        P_IDLE: if (start_i) begin
          m_num = int'(num_ifmap_i); m_wcnt = 0; m_xcnt = 0; m_dcnt = 0; m_stall = 0;
          m_phase = P_LOAD;
        end
        P_LOAD: if (w_valid_i) begin
          m_shadow[m_wcnt] = w_data_i;
          m_wcnt++;
          if (m_wcnt == FC_SIZE) m_phase = P_COMMIT;
        end
        P_COMMIT: begin
          m_wout  = m_shadow;
          m_phase = (m_num == 0) ? P_DRAIN : P_STREAM;
        end
        P_STREAM: begin
          if (x_valid_i) begin
            m_xcnt++;
            if (m_xcnt == m_num) m_phase = P_DRAIN;
          end else if (m_stall < 64'hffff_ffff) begin
            m_stall++;
          end
        end
        P_DRAIN: begin
          if (m_done) m_phase = P_IDLE;
          else begin
            m_dcnt++;
            if (m_dcnt == FC_SIZE) nx_done = 1;
          end
        end
        default: m_phase = P_IDLE;
      endcase
      m_if = nx_if; m_ifv = nx_ifv; m_load = nx_load; m_done = nx_done;
    end
  end

  // Monitors feeding the literal per-job checks
  int         mon_whs, mon_xrdy, mon_load, mon_done, mon_zero, mon_zero_done;
  logic [7:0] mon_w0, mon_w127, mon_prev_w0, last_w0;
  logic [31:0] mon_stall_done;
  logic [7:0] mon_if[$];

  task automatic clear_mon();
    mon_whs = 0; mon_xrdy = 0; mon_load = 0; mon_done = 0; mon_zero = 0;
    mon_zero_done = -1; mon_w0 = 'x; mon_w127 = 'x; mon_prev_w0 = 'x;
    mon_stall_done = 'x; mon_if.delete();
  endtask

  always @(negedge clk) begin : compare
    int bad;
    if (m_live) begin
      chk("w_ready_o", w_ready_o, m_phase == P_LOAD);
      chk("x_ready_o", x_ready_o, m_phase == P_STREAM);
      chk("busy_o", busy_o, m_phase != P_IDLE);
      chk("pe_load_o", pe_load_o, m_load);
      chk("ifmap_valid_o", ifmap_valid_o, m_ifv);
      chk("ifmap_o", ifmap_o, m_if);
      chk("done_o", done_o, m_done);
`ifdef FC_FEEDER_STALL_CNT_EN
      chk("stall_cnt_o", stall_cnt_o, m_stall[31:0]);
`endif
      bad = -1;
      for (int i = FC_SIZE - 1; i >= 0; i--) if (weight_o[i] !== m_wout[i]) bad = i;
      n_tests++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL weight_o[%0d]: got %0h, expected %0h (t=%0t)", bad, weight_o[bad], m_wout[bad], $time);
      end
      if (w_valid_i && w_ready_o) mon_whs++;
      if (x_ready_o) mon_xrdy++;
      if (pe_load_o) begin
        mon_load++; mon_w0 = weight_o[0]; mon_w127 = weight_o[FC_SIZE-1]; mon_prev_w0 = last_w0;
      end
      last_w0 = weight_o[0];
      if (ifmap_valid_o) begin mon_if.push_back(ifmap_o); mon_zero = 0; end
      else if (pe_load_o) mon_zero = 0;
      else if (busy_o) mon_zero++;
      if (done_o) begin
        mon_done++; mon_zero_done = mon_zero;
`ifdef FC_FEEDER_STALL_CNT_EN
        mon_stall_done = stall_cnt_o;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic feed_weights(input int base, input bit toggle, input bit hold_start);
    int k = 0;
    int cyc = 0;
    while (k < FC_SIZE && cyc < 1000) begin
      w_valid_i = toggle ? (cyc % 2 == 0) : 1'b1;
      w_data_i  = 8'(base + k);
      @(negedge clk);
      if (w_valid_i && w_ready_o) k++;
      tick();
      if (!hold_start) start_i = 1'b0;
      cyc++;
    end
    w_valid_i = 1'b0;
    chk("weight_feed_count", k, FC_SIZE);
  endtask

  task automatic feed_ifmap(input int base, input bit pat_en, input int limit);
    logic [4:0] pat = 5'b11001;
    int i = 0;
    int p = 0;
    int cyc = 0;
    while (i < limit && cyc < 1000) begin
      x_valid_i = pat_en ? pat[p % 5] : 1'b1;
      x_data_i  = 8'(base + i);
      @(negedge clk);
      if (x_ready_o) begin
        if (x_valid_i) i++;
        p++;
      end
      tick();
      cyc++;
    end
    x_valid_i = 1'b0;
    chk("ifmap_feed_count", i, limit);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    chk("done_reached", seen, 1);
    tick();
  endtask

  task automatic chk_ifmap(input string nm, input int base, input int n);
    chk({nm, "_count"}, mon_if.size(), n);
    for (int i = 0; i < n; i++) chk($sformatf("%s_%0d", nm, i), mon_if[i], 8'(base + i));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_mon();
    repeat (3) tick();
    // reset state
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_weight_zero", weight_o == '0, 1);
    chk("rst_done", done_o, 0);
    rst = 1'b0;
    tick();

    // basic job: num = 4, weights 1..128, ifmap 0x11..0x14
    clear_mon();
    num_ifmap_i = 16'd4; start_i = 1'b1;
    feed_weights(1, 0, 0);
    feed_ifmap(8'h11, 0, 4);
    wait_done();
    chk("basic_w_handshakes", mon_whs, 128);
    chk("basic_load_pulses", mon_load, 1);
    chk("basic_w0", mon_w0, 8'd1);
    chk("basic_w127", mon_w127, 8'd128);
    chk_ifmap("basic_ifmap", 8'h11, 4);
    chk("basic_drain_zeros", mon_zero_done, 128);
    chk("basic_done_pulses", mon_done, 1);

    // stalls: weight valid 50%, ifmap valid 1,0,0,1,1 with num = 3
    clear_mon();
    num_ifmap_i = 16'd3; start_i = 1'b1;
    feed_weights(8'h40, 1, 0);
    feed_ifmap(8'h21, 1, 3);
    wait_done();
    chk("stall_w0", mon_w0, 8'h40);
    chk("stall_w127", mon_w127, 8'hBF);
    chk_ifmap("stall_ifmap", 8'h21, 3);
    chk("stall_done_pulses", mon_done, 1);
`ifdef FC_FEEDER_STALL_CNT_EN
    chk("stall_cnt_value", mon_stall_done, 32'd2);
`endif

    // zero-length job
    clear_mon();
    num_ifmap_i = 16'd0; start_i = 1'b1;
    feed_weights(8'h05, 0, 0);
    wait_done();
    chk("zero_x_ready_cycles", mon_xrdy, 0);
    chk("zero_load_pulses", mon_load, 1);
    chk("zero_drain_zeros", mon_zero_done, 128);
    chk("zero_done_pulses", mon_done, 1);

    // reset during STREAM after 2 of 5 bytes
    clear_mon();
    num_ifmap_i = 16'd5; start_i = 1'b1;
    feed_weights(8'h60, 0, 0);
    feed_ifmap(8'h31, 0, 2);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("abort_busy", busy_o, 0);
    chk("abort_weight_zero", weight_o == '0, 1);
    chk("abort_ifmap", {ifmap_valid_o, ifmap_o}, 0);
    chk("abort_pe_load", pe_load_o, 0);
    chk("abort_ready", {w_ready_o, x_ready_o}, 0);
    rst = 1'b0;
    repeat (200) tick();
    chk("abort_no_done", mon_done, 0);

    // start held through a whole job; num changes mid-job
    clear_mon();
    num_ifmap_i = 16'd2; start_i = 1'b1;
    feed_weights(8'h70, 0, 1);
    num_ifmap_i = 16'd7;
    feed_ifmap(8'h41, 0, 2);
    wait_done();
    chk_ifmap("held_job1_ifmap", 8'h41, 2);
    chk("held_job1_done", mon_done, 1);
    clear_mon();
    feed_weights(8'h90, 0, 0);
    feed_ifmap(8'h51, 0, 7);
    wait_done();
    chk_ifmap("held_job2_ifmap", 8'h51, 7);
    chk("held_job2_done", mon_done, 1);

    // back-to-back jobs, weights A then B
    num_ifmap_i = 16'd1; start_i = 1'b1;
    feed_weights(8'hA0, 0, 0);
    feed_ifmap(8'h61, 0, 1);
    wait_done();
    clear_mon();
    num_ifmap_i = 16'd1; start_i = 1'b1;
    feed_weights(8'hC0, 0, 0);
    feed_ifmap(8'h62, 0, 1);
    wait_done();
    chk("b2b_w0_before_load", mon_prev_w0, 8'hA0);
    chk("b2b_w0_after_load", mon_w0, 8'hC0);
    chk("b2b_w127_after_load", mon_w127, 8'h3F);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
